// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
// Digit-select decoding and output polarity handling live here.
package seg_scan_pkg;

  localparam int NUM_DIG = 6;
  localparam int SEG_W   = 8;

  typedef logic [2:0] dig_idx_t;

  function automatic logic [SEG_W-1:0] pol(input logic [SEG_W-1:0] value, input logic act_low);
    logic [SEG_W-1:0] res;
    if (act_low) begin
      res = ~value;
    end else begin
      res = value;
    end
    return res;
  endfunction

  function automatic logic [NUM_DIG-1:0] dig_sel(input dig_idx_t idx);
    logic [NUM_DIG-1:0] res;
    case (idx)
      3'd0:    res = 6'b000001;
      3'd1:    res = 6'b000010;
      3'd2:    res = 6'b000100;
      3'd3:    res = 6'b001000;
      3'd4:    res = 6'b010000;
      3'd5:    res = 6'b100000;
      default: res = 6'b000000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_chk.sv
// Protocol checker: the digit-select bus never lights more than one digit.
module seg_scan_chk #(
  parameter int SEL_ACT_LOW = 1
) (
  input logic       clk,
  input logic       rst_n,
  input logic [5:0] sel
);

  localparam logic [5:0] SEL_OFF = (SEL_ACT_LOW != 0) ? 6'h3F : 6'h00;

  sel_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(sel ^ SEL_OFF))
    else $error("sel drives more than one digit: %b", sel);

endmodule

// File: rtl/seg_scan_timer.sv
// Slot timer: counts clocks within a digit slot, steps the digit index,
// flags the blanking window and the edge on which a frame wraps.
module scan_timer
  import seg_scan_pkg::*;
#(
  parameter int DIG_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  output dig_idx_t idx,
  output logic     blank,
  output logic     frame_wrap
);

  localparam int                 CNT_W     = $clog2(DIG_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam dig_idx_t           IDX_LAST  = 3'd5;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  dig_idx_t         idx_r;
  dig_idx_t         idx_nxt_s;
  logic             wrap_s;

  // Next slot position; disabling parks the scan at digit 0, count 0.
  always_comb begin
    cnt_nxt_s = cnt_r;
    idx_nxt_s = idx_r;
    wrap_s    = 1'b0;
    if (!en) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      idx_nxt_s = 3'd0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_nxt_s = 3'd0;
        wrap_s    = 1'b1;
      end else begin
        idx_nxt_s = idx_r + 3'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Slot counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= 3'd0;
    end else begin
      cnt_r <= cnt_nxt_s;
      idx_r <= idx_nxt_s;
    end
  end

  assign idx        = idx_r;
  assign blank      = (cnt_r < BLANK_END);
  assign frame_wrap = wrap_s;

endmodule

// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment driver with per-frame snapshot of the
// segment word and a blanking gap at every digit change.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIG_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int SEL_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_DIG*SEG_W-1:0] din,
  input  logic                   en,
  output logic [NUM_DIG-1:0]     sel,
  output logic [SEG_W-1:0]       seg,
  output logic                   frame_tick
);

  localparam logic               SEL_AL  = (SEL_ACT_LOW != 0);
  localparam logic               SEG_AL  = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIG-1:0] SEL_OFF = {NUM_DIG{SEL_AL}};
  localparam logic [SEG_W-1:0]   SEG_OFF = {SEG_W{SEG_AL}};

  dig_idx_t                 idx_s;
  logic                     blank_s;
  logic                     frame_wrap_s;
  logic                     load_s;
  logic [SEG_W-1:0]         byte_s;
  logic [NUM_DIG-1:0]       sel_nxt_s;
  logic [SEG_W-1:0]         seg_nxt_s;
  logic [NUM_DIG*SEG_W-1:0] snap_r;
  logic                     load_pend_r;
  logic [NUM_DIG-1:0]       sel_r;
  logic [SEG_W-1:0]         seg_r;
  logic                     frame_tick_r;

  scan_timer #(
    .DIG_CYCLES  (DIG_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .idx       (idx_s),
    .blank     (blank_s),
    .frame_wrap(frame_wrap_s)
  );

  // din is only captured between frames, after reset/re-enable, or while idle.
  assign load_s = !en || load_pend_r || frame_wrap_s;

  // Segment byte of the digit currently being scanned.
  always_comb begin
    byte_s = 8'h00;
    case (idx_s)
      3'd0:    byte_s = snap_r[7:0];
      3'd1:    byte_s = snap_r[15:8];
      3'd2:    byte_s = snap_r[23:16];
      3'd3:    byte_s = snap_r[31:24];
      3'd4:    byte_s = snap_r[39:32];
      3'd5:    byte_s = snap_r[47:40];
      default: byte_s = 8'h00;
    endcase
  end

  // Output decode: inactive while disabled or blanking, else light one digit.
  always_comb begin
    sel_nxt_s = SEL_OFF;
    seg_nxt_s = SEG_OFF;
    if (en && !blank_s) begin
      sel_nxt_s = NUM_DIG'(pol({2'b00, dig_sel(idx_s)}, SEL_AL));
      seg_nxt_s = pol(byte_s, SEG_AL);
    end else begin
      sel_nxt_s = SEL_OFF;
      seg_nxt_s = SEG_OFF;
    end
  end

  // Snapshot, pending-load flag and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r       <= {(NUM_DIG*SEG_W){1'b0}};
      load_pend_r  <= 1'b1;
      sel_r        <= SEL_OFF;
      seg_r        <= SEG_OFF;
      frame_tick_r <= 1'b0;
    end else begin
      if (load_s) begin
        snap_r <= din;
      end
      // Re-arm while idle so the first enabled edge reloads and ticks.
      load_pend_r  <= !en;
      sel_r        <= sel_nxt_s;
      seg_r        <= seg_nxt_s;
      frame_tick_r <= en && (load_pend_r || frame_wrap_s);
    end
  end

  assign sel        = sel_r;
  assign seg        = seg_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: an active-low and an active-high instance
// share stimulus; expectations are queued in logical (active-high) form.
module tb_seg_scan;

  localparam int DIG = 8;
  localparam int BLK = 2;

  localparam logic [47:0] W1 = 48'h0000_0000_003F;
  localparam logic [47:0] P  = 48'h7F_6F_5B_4F_06_3F;
  localparam logic [47:0] Q  = 48'h01_02_04_08_10_20;
  localparam logic [47:0] R  = 48'hA5_5A_C3_3C_99_66;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [47:0] din;
  logic [5:0]  sel_lo, sel_hi;
  logic [7:0]  seg_lo, seg_hi;
  logic        tick_lo, tick_hi;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  seg_scan #(.DIG_CYCLES(DIG), .BLANK_CYCLES(BLK), .SEL_ACT_LOW(1), .SEG_ACT_LOW(1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en),
    .sel(sel_lo), .seg(seg_lo), .frame_tick(tick_lo)
  );

  seg_scan #(.DIG_CYCLES(DIG), .BLANK_CYCLES(BLK), .SEL_ACT_LOW(0), .SEG_ACT_LOW(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en),
    .sel(sel_hi), .seg(seg_hi), .frame_tick(tick_hi)
  );

  seg_scan_chk #(.SEL_ACT_LOW(1)) chk_lo (.clk(clk), .rst_n(rst_n), .sel(sel_lo));
  seg_scan_chk #(.SEL_ACT_LOW(0)) chk_hi (.clk(clk), .rst_n(rst_n), .sel(sel_hi));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("sel_lo",  {2'b00, sel_lo},  {2'b00, ~mon_e.sel});
      check("seg_lo",  seg_lo,           ~mon_e.seg);
      check("tick_lo", {7'd0, tick_lo},  {7'd0, mon_e.tick});
      check("sel_hi",  {2'b00, sel_hi},  {2'b00, mon_e.sel});
      check("seg_hi",  seg_hi,           mon_e.seg);
      check("tick_hi", {7'd0, tick_hi},  {7'd0, mon_e.tick});
    end
  end

  task automatic push(input logic [5:0] s, input logic [7:0] g, input logic t);
    exp_t e;
    e.sel  = s;
    e.seg  = g;
    e.tick = t;
    q.push_back(e);
  endtask

  task automatic push_off(input int n);
    for (int k = 0; k < n; k++) push(6'h00, 8'h00, 1'b0);
  endtask

  // Cycle i of the scan after a load: digit (i/8)%6, position i%8 in its slot.
  task automatic push_cyc(input int i, input logic [47:0] w);
    int   d;
    int   c;
    logic t;
    d = (i / DIG) % 6;
    c = i % DIG;
    t = ((i % (6 * DIG)) == (6 * DIG - 1)) || (i == 0);
    if (c < BLK) push(6'h00, 8'h00, t);
    else         push(6'b000001 << d, w[8*d +: 8], t);
  endtask

  task automatic push_run(input int i0, input int i1, input logic [47:0] w);
    for (int i = i0; i <= i1; i++) push_cyc(i, w);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    din   = W1;
    step(2);

    // Release reset: blank 2, then digit 0 = 3F (pins C0 / 3E), tick on first edge.
    push_off(1);
    rst_n = 1'b1;
    push_run(0, 19, W1);
    step(21);

    // din changes inside digit 2: rest of frame stays old, next frame shows P.
    din = P;
    push_run(20, 47, W1);
    push_run(48, 99, P);
    step(80);

    // Disable mid-DRIVE of digit 0; change din while idle.
    en  = 1'b0;
    din = Q;
    push_cyc(100, P);
    push_off(5);
    step(6);

    // Re-enable: restart at digit 0 with Q and a tick.
    en = 1'b1;
    push_off(1);
    push_run(0, 35, Q);
    step(37);

    // Async reset in the middle of digit 4's drive phase.
    rst_n = 1'b0;
    din   = R;
    push_off(2);
    step(2);
    rst_n = 1'b1;
    push_off(1);
    push_run(0, 47, R);
    step(49);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
